// File: rtl/ex_unit_pkg.sv
// Shared definitions for the execute stage: operation encodings, reset level,
// zero word and the divider state type.
package ex_defs;
  localparam logic       RSTENABLE = 1'b1;
  localparam int         MAX_W     = 64;
  localparam logic [MAX_W-1:0] ZEROWORD = '0;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_AND   = 8'h24;
  localparam logic [7:0] OP_OR    = 8'h25;
  localparam logic [7:0] OP_XOR   = 8'h26;
  localparam logic [7:0] OP_NOR   = 8'h27;
  localparam logic [7:0] OP_SLL   = 8'h7C;
  localparam logic [7:0] OP_SRL   = 8'h02;
  localparam logic [7:0] OP_SRA   = 8'h03;
  localparam logic [7:0] OP_ADDU  = 8'h21;
  localparam logic [7:0] OP_SUBU  = 8'h23;
  localparam logic [7:0] OP_SLT   = 8'h2A;
  localparam logic [7:0] OP_SLTU  = 8'h2B;
  localparam logic [7:0] OP_MULT  = 8'h18;
  localparam logic [7:0] OP_MULTU = 8'h19;
  localparam logic [7:0] OP_DIV   = 8'h1A;
  localparam logic [7:0] OP_DIVU  = 8'h1B;
  localparam logic [7:0] OP_MFHI  = 8'h10;
  localparam logic [7:0] OP_MTHI  = 8'h11;
  localparam logic [7:0] OP_MFLO  = 8'h12;
  localparam logic [7:0] OP_MTLO  = 8'h13;

  // HI/LO-only ops (MULT, DIV, MTHI, MTLO) travel with SEL_NOP.
  localparam logic [2:0] SEL_NOP   = 3'b000;
  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_MOVE  = 3'b011;
  localparam logic [2:0] SEL_ARITH = 3'b100;

  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_e;
endpackage

// File: rtl/ex_unit_if.sv
// ID/EX-side inputs and EX/MEM-side outputs of the execute stage.
interface ex_unit_if #(parameter int DATA_W = 32, parameter int REGADDR_W = 5);
  logic [7:0]           aluop_i;
  logic [2:0]           alusel_i;
  logic [DATA_W-1:0]    reg1_i;
  logic [DATA_W-1:0]    reg2_i;
  logic [REGADDR_W-1:0] wd_i;
  logic                 wreg_i;
  logic [DATA_W-1:0]    hi_i;
  logic [DATA_W-1:0]    lo_i;
  logic [REGADDR_W-1:0] wd_o;
  logic                 wreg_o;
  logic [DATA_W-1:0]    wdata_o;
  logic                 whilo_o;
  logic [DATA_W-1:0]    hi_o;
  logic [DATA_W-1:0]    lo_o;
  logic                 stallreq_o;

  modport master (
    output aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, hi_i, lo_i,
    input  wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
  );
  modport slave (
    input  aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, hi_i, lo_i,
    output wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
  );
endinterface

// File: rtl/ex_unit_div.sv
// Iterative restoring divider: one quotient bit per cycle on operand magnitudes,
// sign fixup applied to the latched result.
module div_iter
  import ex_defs::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              signed_op,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);
  localparam int CNT_W = $clog2(DATA_W);

  div_state_e        r_state, w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_quo, r_rem, r_dvs;
  logic              r_neg_q, r_neg_r;
  logic [DATA_W-1:0] w_abs_a, w_abs_b;
  logic [DATA_W:0]   w_trial, w_diff;

  assign w_abs_a = (signed_op && op_a[DATA_W-1]) ? -op_a : op_a;
  assign w_abs_b = (signed_op && op_b[DATA_W-1]) ? -op_b : op_b;

  // r_quo doubles as the dividend shift register; its MSB feeds the trial subtract.
  assign w_trial = {r_rem, r_quo[DATA_W-1]};
  assign w_diff  = w_trial - {1'b0, r_dvs};

  always_ff @(posedge clk) begin
    if (rst == RSTENABLE) r_state <= DIV_IDLE;
    else                  r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      DIV_IDLE: if (start) begin
        busy   = 1'b1;
        w_next = (op_b == '0) ? DIV_DONE : DIV_BUSY;
      end
      DIV_BUSY: begin
        busy = 1'b1;
        if (r_cnt == CNT_W'(DATA_W-1)) w_next = DIV_DONE;
      end
      DIV_DONE: begin
        done   = 1'b1;
        w_next = DIV_IDLE;
      end
      default: w_next = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RSTENABLE) begin
      r_cnt   <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_dvs   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else begin
      case (r_state)
        DIV_IDLE: if (start) begin
          r_cnt <= '0;
          r_rem <= '0;
          if (op_b == '0) begin
            r_quo   <= '0;
            r_dvs   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
          end else begin
            r_quo   <= w_abs_a;
            r_dvs   <= w_abs_b;
            r_neg_q <= signed_op & (op_a[DATA_W-1] ^ op_b[DATA_W-1]);
            r_neg_r <= signed_op & op_a[DATA_W-1];
          end
        end
        DIV_BUSY: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (!w_diff[DATA_W]) begin
            r_rem <= w_diff[DATA_W-1:0];
            r_quo <= {r_quo[DATA_W-2:0], 1'b1};
          end else begin
            r_rem <= w_trial[DATA_W-1:0];
            r_quo <= {r_quo[DATA_W-2:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  assign quotient  = r_neg_q ? -r_quo : r_quo;
  assign remainder = r_neg_r ? -r_rem : r_rem;
endmodule

// File: rtl/ex_unit.sv
// Execute stage: single-cycle logic/shift/arith/compare/multiply/HI-LO moves,
// plus an optional multi-cycle divider that stalls the pipeline.
module ex_unit
  import ex_defs::*;
#(
  parameter int DATA_W    = 32,
  parameter int REGADDR_W = 5,
  parameter int DIV_EN    = 1
) (
  input logic clk,
  input logic rst,
  ex_unit_if.slave ex_bus
);
  localparam int SH_W = $clog2(DATA_W);

  logic [SH_W-1:0]     w_shamt;
  logic [DATA_W-1:0]   w_logic, w_shift, w_arith, w_move, w_wdata, w_hi, w_lo;
  logic [2*DATA_W-1:0] w_ma, w_mb, w_prod;
  logic                w_whilo, w_mul_op, w_div_op, w_div_start;
  logic                w_div_busy, w_div_done;
  logic [DATA_W-1:0]   w_quo, w_rem;

  assign w_shamt  = ex_bus.reg1_i[SH_W-1:0];
  assign w_mul_op = (ex_bus.aluop_i == OP_MULT) || (ex_bus.aluop_i == OP_MULTU);
  assign w_div_op = (ex_bus.aluop_i == OP_DIV)  || (ex_bus.aluop_i == OP_DIVU);
  assign w_div_start = w_div_op && (ex_bus.alusel_i == SEL_NOP);

  always_comb begin
    w_logic = '0;
    w_shift = '0;
    w_arith = '0;
    w_move  = '0;
    case (ex_bus.aluop_i)
      OP_OR:   w_logic = ex_bus.reg1_i | ex_bus.reg2_i;
      OP_AND:  w_logic = ex_bus.reg1_i & ex_bus.reg2_i;
      OP_XOR:  w_logic = ex_bus.reg1_i ^ ex_bus.reg2_i;
      OP_NOR:  w_logic = ~(ex_bus.reg1_i | ex_bus.reg2_i);
      OP_SLL:  w_shift = ex_bus.reg2_i << w_shamt;
      OP_SRL:  w_shift = ex_bus.reg2_i >> w_shamt;
      OP_SRA:  w_shift = $unsigned($signed(ex_bus.reg2_i) >>> w_shamt);
      OP_ADDU: w_arith = ex_bus.reg1_i + ex_bus.reg2_i;
      OP_SUBU: w_arith = ex_bus.reg1_i - ex_bus.reg2_i;
      OP_SLT:  w_arith = {{(DATA_W-1){1'b0}}, ($signed(ex_bus.reg1_i) < $signed(ex_bus.reg2_i))};
      OP_SLTU: w_arith = {{(DATA_W-1){1'b0}}, (ex_bus.reg1_i < ex_bus.reg2_i)};
      OP_MFHI: w_move  = ex_bus.hi_i;
      OP_MFLO: w_move  = ex_bus.lo_i;
      default: ;
    endcase
  end

  always_comb begin
    case (ex_bus.alusel_i)
      SEL_LOGIC: w_wdata = w_logic;
      SEL_SHIFT: w_wdata = w_shift;
      SEL_ARITH: w_wdata = w_arith;
      SEL_MOVE:  w_wdata = w_move;
      default:   w_wdata = '0;
    endcase
  end

  // Extend to 2*DATA_W so one unsigned multiplier serves both MULT and MULTU.
  assign w_ma   = {{DATA_W{(ex_bus.aluop_i == OP_MULT) & ex_bus.reg1_i[DATA_W-1]}}, ex_bus.reg1_i};
  assign w_mb   = {{DATA_W{(ex_bus.aluop_i == OP_MULT) & ex_bus.reg2_i[DATA_W-1]}}, ex_bus.reg2_i};
  assign w_prod = w_ma * w_mb;

  always_comb begin
    w_whilo = 1'b0;
    w_hi    = '0;
    w_lo    = '0;
    if (ex_bus.alusel_i == SEL_NOP) begin
      case (ex_bus.aluop_i)
        OP_MULT, OP_MULTU: begin
          w_whilo      = 1'b1;
          {w_hi, w_lo} = w_prod;
        end
        OP_MTHI: begin
          w_whilo = 1'b1;
          w_hi    = ex_bus.reg1_i;
          w_lo    = ex_bus.lo_i;
        end
        OP_MTLO: begin
          w_whilo = 1'b1;
          w_hi    = ex_bus.hi_i;
          w_lo    = ex_bus.reg1_i;
        end
        OP_DIV, OP_DIVU: if (w_div_done) begin
          w_whilo = 1'b1;
          w_hi    = w_rem;
          w_lo    = w_quo;
        end
        default: ;
      endcase
    end
  end

  generate
    if (DIV_EN != 0) begin : g_div
      div_iter #(.DATA_W(DATA_W)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (w_div_start),
        .signed_op (ex_bus.aluop_i == OP_DIV),
        .op_a      (ex_bus.reg1_i),
        .op_b      (ex_bus.reg2_i),
        .busy      (w_div_busy),
        .done      (w_div_done),
        .quotient  (w_quo),
        .remainder (w_rem)
      );
    end else begin : g_nodiv
      assign w_div_busy = 1'b0;
      assign w_div_done = 1'b0;
      assign w_quo      = '0;
      assign w_rem      = '0;
    end
  endgenerate

  assign ex_bus.wd_o       = (rst == RSTENABLE) ? '0 : ex_bus.wd_i;
  assign ex_bus.wreg_o     = (rst == RSTENABLE) ? 1'b0 : (ex_bus.wreg_i & ~(w_mul_op | w_div_op));
  assign ex_bus.wdata_o    = (rst == RSTENABLE) ? ZEROWORD[DATA_W-1:0] : w_wdata;
  assign ex_bus.whilo_o    = (rst == RSTENABLE) ? 1'b0 : w_whilo;
  assign ex_bus.hi_o       = (rst == RSTENABLE) ? ZEROWORD[DATA_W-1:0] : w_hi;
  assign ex_bus.lo_o       = (rst == RSTENABLE) ? ZEROWORD[DATA_W-1:0] : w_lo;
  assign ex_bus.stallreq_o = (rst == RSTENABLE) ? 1'b0 : w_div_busy;
endmodule

// File: tb/tb_ex_unit.sv
// Scoreboard bench for ex_unit: directed ops push expected results, a monitor
// pops and compares whenever the stage presents a non-stalled result.
module tb_ex_unit;
  import ex_defs::*;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ex_unit_if #(.DATA_W(DW), .REGADDR_W(AW)) bus ();
  ex_unit #(.DATA_W(DW), .REGADDR_W(AW), .DIV_EN(1)) dut (.clk(clk), .rst(rst), .ex_bus(bus));

  typedef struct {
    string          name;
    logic [AW-1:0]  wd;
    logic           wreg;
    logic [DW-1:0]  wdata;
    logic           chk_wdata;
    logic           whilo;
    logic [DW-1:0]  hi, lo;
    logic           chk_hilo;
    int             stall;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  logic vld = 1'b0;

  function automatic exp_t ew(input string nm, input logic [AW-1:0] wd, input logic wr,
                              input logic [DW-1:0] d);
    exp_t e;
    e.name = nm; e.wd = wd; e.wreg = wr; e.wdata = d; e.chk_wdata = 1'b1;
    e.whilo = 1'b0; e.hi = '0; e.lo = '0; e.chk_hilo = 1'b0; e.stall = 0;
    return e;
  endfunction

  function automatic exp_t eh(input string nm, input logic [AW-1:0] wd,
                              input logic [DW-1:0] h, input logic [DW-1:0] l, input int st);
    exp_t e;
    e.name = nm; e.wd = wd; e.wreg = 1'b0; e.wdata = '0; e.chk_wdata = 1'b0;
    e.whilo = 1'b1; e.hi = h; e.lo = l; e.chk_hilo = 1'b1; e.stall = st;
    return e;
  endfunction

  task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic [AW-1:0] wd, input logic wr,
                       input logic [DW-1:0] h, input logic [DW-1:0] l);
    bus.aluop_i = op; bus.alusel_i = sel; bus.reg1_i = a; bus.reg2_i = b;
    bus.wd_i = wd; bus.wreg_i = wr; bus.hi_i = h; bus.lo_i = l;
  endtask

  // Called at posedge+1 with inputs already driven; holds them until the result cycle.
  task automatic run(input exp_t e);
    int n;
    sb.push_back(e);
    vld = 1'b1;
    n = 0;
    @(negedge clk);
    while (bus.stallreq_o && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL %s_timeout: stallreq_o still 1 after %0d cycles, required to drop", e.name, n);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string nm);
    checks++;
    if (bus.wd_o !== '0 || bus.wreg_o !== 1'b0 || bus.wdata_o !== '0 || bus.whilo_o !== 1'b0 ||
        bus.hi_o !== '0 || bus.lo_o !== '0 || bus.stallreq_o !== 1'b0) begin
      errors++;
      $display("FAIL %s: got wd=%0d wreg=%b wdata=%h whilo=%b hi=%h lo=%h stall=%b, required all 0",
               nm, bus.wd_o, bus.wreg_o, bus.wdata_o, bus.whilo_o, bus.hi_o, bus.lo_o, bus.stallreq_o);
    end
  endtask

  initial begin : monitor
    exp_t e;
    int   sc;
    logic ok;
    sc = 0;
    forever begin
      @(negedge clk);
      if (!vld) sc = 0;
      else if (bus.stallreq_o) sc++;
      else begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: whilo=%b wdata=%h with empty scoreboard", bus.whilo_o, bus.wdata_o);
        end else begin
          e = sb.pop_front();
          checks++;
          ok = (bus.wd_o === e.wd) && (bus.wreg_o === e.wreg) && (bus.whilo_o === e.whilo) &&
               (!e.chk_wdata || bus.wdata_o === e.wdata) &&
               (!e.chk_hilo || (bus.hi_o === e.hi && bus.lo_o === e.lo));
          if (!ok) begin
            errors++;
            $display("FAIL %s: got wd=%0d wreg=%b wdata=%h whilo=%b hi=%h lo=%h, required wd=%0d wreg=%b wdata=%h whilo=%b hi=%h lo=%h",
                     e.name, bus.wd_o, bus.wreg_o, bus.wdata_o, bus.whilo_o, bus.hi_o, bus.lo_o,
                     e.wd, e.wreg, e.wdata, e.whilo, e.hi, e.lo);
          end
          checks++;
          if (sc != e.stall) begin
            errors++;
            $display("FAIL %s_stall: got %0d stall cycles, required %0d", e.name, sc, e.stall);
          end
        end
        sc = 0;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic ok;
    drive(OP_OR, SEL_LOGIC, 32'h0F0F0000, 32'h000000FF, 5'd3, 1'b1, 32'h1, 32'h2);
    @(negedge clk);
    check_all_zero("reset_outputs");
    @(posedge clk); #1;
    drive(OP_DIV, SEL_NOP, 32'd9, 32'd2, 5'd1, 1'b1, 32'h0, 32'h0);
    @(negedge clk);
    check_all_zero("reset_div_no_stall");
    @(posedge clk); #1;
    rst = 1'b0;

    drive(OP_OR,   SEL_LOGIC, 32'h0F0F0000, 32'h000000FF, 5'd3, 1'b1, 0, 0); run(ew("or",   3, 1, 32'h0F0F00FF));
    drive(OP_AND,  SEL_LOGIC, 32'hFF00FF00, 32'h0FF00FF0, 5'd4, 1'b1, 0, 0); run(ew("and",  4, 1, 32'h0F000F00));
    drive(OP_XOR,  SEL_LOGIC, 32'hFFFF0000, 32'h0F0F0F0F, 5'd5, 1'b1, 0, 0); run(ew("xor",  5, 1, 32'hF0F00F0F));
    drive(OP_NOR,  SEL_LOGIC, 32'hF0F0F0F0, 32'h0000000F, 5'd6, 1'b1, 0, 0); run(ew("nor",  6, 1, 32'h0F0F0F00));
    drive(OP_SLT,  SEL_ARITH, 32'hFFFFFFFF, 32'h00000001, 5'd7, 1'b1, 0, 0); run(ew("slt",  7, 1, 32'h1));
    drive(OP_SLTU, SEL_ARITH, 32'hFFFFFFFF, 32'h00000001, 5'd8, 1'b1, 0, 0); run(ew("sltu", 8, 1, 32'h0));
    drive(OP_ADDU, SEL_ARITH, 32'hFFFFFFFF, 32'h00000002, 5'd9, 1'b1, 0, 0); run(ew("addu_wrap", 9, 1, 32'h1));
    drive(OP_SUBU, SEL_ARITH, 32'h00000000, 32'h00000001, 5'd10, 1'b0, 0, 0); run(ew("subu_wrap", 10, 0, 32'hFFFFFFFF));
    drive(OP_SRA,  SEL_SHIFT, 32'd36, 32'h80000010, 5'd11, 1'b1, 0, 0); run(ew("sra_mod", 11, 1, 32'hF8000001));
    drive(OP_SRL,  SEL_SHIFT, 32'd36, 32'h80000010, 5'd12, 1'b1, 0, 0); run(ew("srl_mod", 12, 1, 32'h08000001));
    drive(OP_SLL,  SEL_SHIFT, 32'd31, 32'h00000003, 5'd13, 1'b1, 0, 0); run(ew("sll_31", 13, 1, 32'h80000000));
    drive(OP_MULT, SEL_NOP, 32'hFFFFFFFD, 32'd5, 5'd7, 1'b1, 0, 0);  run(eh("mult",  7, 32'hFFFFFFFF, 32'hFFFFFFF1, 0));
    drive(OP_MULTU, SEL_NOP, 32'hFFFFFFFD, 32'd5, 5'd7, 1'b1, 0, 0); run(eh("multu", 7, 32'h00000004, 32'hFFFFFFF1, 0));
    drive(OP_MTHI, SEL_NOP, 32'h12345678, 0, 5'd0, 1'b0, 32'h99999999, 32'hCAFEBABE);
    run(eh("mthi", 0, 32'h12345678, 32'hCAFEBABE, 0));
    drive(OP_MTLO, SEL_NOP, 32'hA5A5A5A5, 0, 5'd0, 1'b0, 32'h11111111, 32'h22222222);
    run(eh("mtlo", 0, 32'h11111111, 32'hA5A5A5A5, 0));
    drive(OP_MFHI, SEL_MOVE, 0, 0, 5'd14, 1'b1, 32'hDEADBEEF, 32'h01234567); run(ew("mfhi", 14, 1, 32'hDEADBEEF));
    drive(OP_MFLO, SEL_MOVE, 0, 0, 5'd15, 1'b1, 32'hDEADBEEF, 32'h01234567); run(ew("mflo", 15, 1, 32'h01234567));
    drive(8'hFF, SEL_LOGIC, 32'hFFFFFFFF, 32'h1, 5'd4, 1'b1, 0, 0);  run(ew("bad_aluop", 4, 1, 32'h0));
    drive(OP_MTHI, 3'b111, 32'h5, 32'h6, 5'd2, 1'b0, 0, 0);          run(ew("bad_alusel", 2, 0, 32'h0));

    drive(OP_DIV,  SEL_NOP, 32'hFFFFFFF9, 32'd2, 5'd1, 1'b1, 0, 0); run(eh("div_neg", 1, 32'hFFFFFFFF, 32'hFFFFFFFD, 33));
    drive(OP_DIVU, SEL_NOP, 32'd7, 32'd2, 5'd1, 1'b1, 0, 0);        run(eh("divu", 1, 32'd1, 32'd3, 33));
    drive(OP_DIV,  SEL_NOP, 32'd123, 32'd0, 5'd1, 1'b1, 0, 0);      run(eh("div_zero", 1, 32'd0, 32'd0, 1));
    drive(OP_DIV,  SEL_NOP, 32'h80000000, 32'hFFFFFFFF, 5'd1, 1'b1, 0, 0);
    run(eh("div_min_neg1", 1, 32'd0, 32'h80000000, 33));

    // Abort a divide with a one-cycle reset at iteration 10.
    drive(OP_DIV, SEL_NOP, 32'd50, 32'd3, 5'd1, 1'b1, 0, 0);
    vld = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    rst = 1'b1;
    vld = 1'b0;
    @(negedge clk);
    check_all_zero("reset_mid_div");
    @(posedge clk); #1;
    rst = 1'b0;
    drive(OP_NOP, SEL_NOP, 0, 0, 5'd0, 1'b0, 0, 0);
    ok = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.stallreq_o !== 1'b0 || bus.whilo_o !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL after_reset_idle: stall=%b whilo=%b, required 0 and 0", bus.stallreq_o, bus.whilo_o);
    end
    @(posedge clk); #1;
    drive(OP_DIV, SEL_NOP, 32'd100, 32'd7, 5'd1, 1'b1, 0, 0); run(eh("div_after_rst", 1, 32'd2, 32'd14, 33));

    drive(OP_NOP, SEL_NOP, 0, 0, 5'd0, 1'b0, 0, 0);
    vld = 1'b0;
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
